// File: rtl/sort_out_serializer.sv
// ============================================================================
// sort_out_serializer
// ----------------------------------------------------------------------------
// Buffers sorted four-element groups in a small FIFO and streams them out one
// element per cycle over a valid/ready interface, element 0 first.
//
// Upstream has no backpressure. A group that arrives while the FIFO is full is
// dropped, and the sticky overflow flag records the loss. The one exception is
// the cycle in which the head group's last element leaves: that frees a slot,
// so the incoming group is accepted in the same cycle.
//
// Optional feature (compile-time macro):
//   SORT_OUT_SERIALIZER_ORDER_CHECK_EN
//     Defined   : every accepted group is checked for in0<=in1<=in2<=in3
//                 (unsigned). A violation sets the sticky order_err flag. The
//                 group is still buffered and emitted unchanged.
//     Undefined : the check logic is absent and order_err is tied to 0.
//
// Parameters:
//   p_nbits  element width in bits (>= 1)
//   p_depth  number of buffered groups (power of two, >= 2)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   in_val     in   a sorted group is present this cycle
//   in0..in3   in   group elements, in ascending order
//   out_val    out  out_msg holds a valid element
//   out_rdy    in   downstream accepts out_msg this cycle
//   out_msg    out  current element (0 when out_val=0)
//   out_last   out  current element is element 3 of its group
//   overflow   out  sticky flag: a group was dropped
//   order_err  out  sticky flag: an accepted group was out of order
// ============================================================================
module sort_out_serializer #(
    parameter int p_nbits = 8,
    parameter int p_depth = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_val,
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    input  logic [p_nbits-1:0] in2,
    input  logic [p_nbits-1:0] in3,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out_msg,
    output logic               out_last,
    output logic               overflow,
    output logic               order_err
);

    localparam int c_aw = $clog2(p_depth);
    localparam int c_cw = c_aw + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_aw-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cw-1:0] count_q,  count_d;
    logic [1:0]      idx_q,    idx_d;
    logic            overflow_q, overflow_d;

    // Group storage. Element k of a group lives at index [k].
    logic [3:0][p_nbits-1:0] grp_q [p_depth];

    // ------------------------------------------------------------------
    // Incoming group, packed so element k sits at index [k]
    // ------------------------------------------------------------------
    logic [3:0][p_nbits-1:0] in_grp;
    assign in_grp = {in3, in2, in1, in0};

    // ------------------------------------------------------------------
    // Handshake and FIFO control
    // ------------------------------------------------------------------
    logic fire;
    logic fire_last;
    logic full;
    logic can_accept;
    logic enq;
    logic drop;

    assign out_val    = (count_q != '0);
    assign fire       = out_val & out_rdy;
    assign fire_last  = fire & (idx_q == 2'd3);
    assign full       = (count_q == c_cw'(p_depth));
    // A full FIFO still takes a group when its head slot drains this cycle.
    assign can_accept = ~full | fire_last;
    assign enq        = in_val & can_accept;
    assign drop       = in_val & ~can_accept;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        idx_d      = idx_q;
        overflow_d = overflow_q | drop;

        if (enq) begin
            // Power-of-two depth, so the natural wrap is modulo p_depth.
            wr_ptr_d = wr_ptr_q + c_aw'(1);
        end

        if (fire) begin
            if (idx_q == 2'd3) begin
                idx_d    = 2'd0;
                rd_ptr_d = rd_ptr_q + c_aw'(1);
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end

        // Enqueue together with a last-element fire leaves count unchanged.
        case ({enq, fire_last})
            2'b10:   count_d = count_q + c_cw'(1);
            2'b01:   count_d = count_q - c_cw'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            idx_q      <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: an entry is only read while count covers it.
    // enq is masked during reset so nothing is written in that cycle.
    always_ff @(posedge clk) begin
        if (reset && enq) begin
            grp_q[wr_ptr_q] <= in_grp;
        end
    end

    // ------------------------------------------------------------------
    // Output path. Element select comes straight from registered state,
    // so out_msg and out_last hold while the consumer stalls.
    // ------------------------------------------------------------------
    always_comb begin
        out_msg = '0;
        if (out_val) begin
            out_msg = grp_q[rd_ptr_q][idx_q];
        end
    end

    assign out_last = out_val & (idx_q == 2'd3);
    assign overflow = overflow_q;

    // ------------------------------------------------------------------
    // Optional ordering check on accepted groups
    // ------------------------------------------------------------------
`ifdef SORT_OUT_SERIALIZER_ORDER_CHECK_EN
    logic [2:0] pair_ok;
    logic       order_err_q, order_err_d;

    for (genvar gi = 0; gi < 3; gi++) begin : g_pair
        assign pair_ok[gi] = (in_grp[gi] <= in_grp[gi+1]);
    end

    // Only accepted groups count; a dropped group never flags.
    always_comb begin
        order_err_d = order_err_q | (enq & ~(&pair_ok));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            order_err_q <= 1'b0;
        end else begin
            order_err_q <= order_err_d;
        end
    end

    assign order_err = order_err_q;
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_out_serializer.sv
// ============================================================================
// tb_sort_out_serializer
// ----------------------------------------------------------------------------
// Table-driven bench for sort_out_serializer (p_nbits=8, p_depth=2).
// Each table row is one clock cycle: the inputs driven in that cycle and the
// outputs expected in that same cycle, before the next rising edge. A short
// hand-written sequence then covers the ordering-check behaviour.
// ============================================================================
module tb_sort_out_serializer;

`ifdef SORT_OUT_SERIALIZER_ORDER_CHECK_EN
    localparam bit EXP_OC = 1'b1;
`else
    localparam bit EXP_OC = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       in_val;
    logic [7:0] in0, in1, in2, in3;
    logic       out_val;
    logic       out_rdy;
    logic [7:0] out_msg;
    logic       out_last;
    logic       overflow;
    logic       order_err;

    int n_checks = 0;
    int n_errors = 0;

    sort_out_serializer #(
        .p_nbits (8),
        .p_depth (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_val    (in_val),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .out_msg   (out_msg),
        .out_last  (out_last),
        .overflow  (overflow),
        .order_err (order_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst;   // reset pin value (active low)
        bit         iv;
        logic [31:0] grp;  // {in0,in1,in2,in3}
        bit         rdy;
        bit         chk;
        bit         ev;
        logic [7:0] em;
        bit         el;
        bit         eo;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit rst, input bit iv, input logic [31:0] grp,
                                input bit rdy, input bit chk, input bit ev,
                                input logic [7:0] em, input bit el, input bit eo);
        vec_t v;
        v.rst = rst; v.iv = iv; v.grp = grp; v.rdy = rdy;
        v.chk = chk; v.ev = ev; v.em = em; v.el = el; v.eo = eo;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit iv, input logic [31:0] g, input bit rdy);
        @(negedge clk);
        reset   = r;
        in_val  = iv;
        in0     = g[31:24];
        in1     = g[23:16];
        in2     = g[15:8];
        in3     = g[7:0];
        out_rdy = rdy;
        #1;
    endtask

    initial begin
        reset = 1'b0; in_val = 1'b0; out_rdy = 1'b0;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0;

        // ---- reset, in_val ignored during reset ----------------------
        add(0, 1, 32'h99999999, 1, 0, 0, 8'h00, 0, 0);
        add(0, 1, 32'h99999999, 1, 1, 0, 8'h00, 0, 0);
        // ---- single group, 1-cycle latency ---------------------------
        add(1, 1, 32'h01030507, 1, 1, 0, 8'h00, 0, 0);
        add(1, 0, 32'h0,        1, 1, 1, 8'h01, 0, 0);
        add(1, 0, 32'h0,        1, 1, 1, 8'h03, 0, 0);
        add(1, 0, 32'h0,        1, 1, 1, 8'h05, 0, 0);
        add(1, 0, 32'h0,        1, 1, 1, 8'h07, 1, 0);
        // ---- backpressure: 3 stalls then alternating ready -----------
        add(1, 1, 32'h10203040, 0, 1, 0, 8'h00, 0, 0);
        add(1, 0, 32'h0,        0, 1, 1, 8'h10, 0, 0);
        add(1, 0, 32'h0,        0, 1, 1, 8'h10, 0, 0);
        add(1, 0, 32'h0,        0, 1, 1, 8'h10, 0, 0);
        add(1, 0, 32'h0,        1, 1, 1, 8'h10, 0, 0);
        add(1, 0, 32'h0,        0, 1, 1, 8'h20, 0, 0);
        add(1, 0, 32'h0,        1, 1, 1, 8'h20, 0, 0);
        add(1, 0, 32'h0,        0, 1, 1, 8'h30, 0, 0);
        add(1, 0, 32'h0,        1, 1, 1, 8'h30, 0, 0);
        add(1, 0, 32'h0,        0, 1, 1, 8'h40, 1, 0);
        add(1, 0, 32'h0,        1, 1, 1, 8'h40, 1, 0);
        // ---- overflow: third group of three is dropped ---------------
        add(1, 1, 32'h01020304, 0, 1, 0, 8'h00, 0, 0);
        add(1, 1, 32'h11121314, 0, 1, 1, 8'h01, 0, 0);
        add(1, 1, 32'h21222324, 0, 1, 1, 8'h01, 0, 0);
        add(1, 0, 32'h0,        1, 1, 1, 8'h01, 0, 1);
        add(1, 0, 32'h0,        1, 1, 1, 8'h02, 0, 1);
        add(1, 0, 32'h0,        1, 1, 1, 8'h03, 0, 1);
        add(1, 0, 32'h0,        1, 1, 1, 8'h04, 1, 1);
        add(1, 0, 32'h0,        1, 1, 1, 8'h11, 0, 1);
        add(1, 0, 32'h0,        1, 1, 1, 8'h12, 0, 1);
        add(1, 0, 32'h0,        1, 1, 1, 8'h13, 0, 1);
        add(1, 0, 32'h0,        1, 1, 1, 8'h14, 1, 1);
        add(0, 0, 32'h0,        1, 1, 0, 8'h00, 0, 1);
        // ---- full FIFO with simultaneous last-element fire -----------
        add(1, 1, 32'h01020304, 0, 1, 0, 8'h00, 0, 0);
        add(1, 1, 32'h05060708, 0, 1, 1, 8'h01, 0, 0);
        add(1, 0, 32'h0,        1, 1, 1, 8'h01, 0, 0);
        add(1, 0, 32'h0,        1, 1, 1, 8'h02, 0, 0);
        add(1, 0, 32'h0,        1, 1, 1, 8'h03, 0, 0);
        add(1, 1, 32'hAABBCCDD, 1, 1, 1, 8'h04, 1, 0);
        // count still 2: a group offered mid-group is dropped
        add(1, 1, 32'hE0E1E2E3, 1, 1, 1, 8'h05, 0, 0);
        add(1, 0, 32'h0,        1, 1, 1, 8'h06, 0, 1);
        add(1, 0, 32'h0,        1, 1, 1, 8'h07, 0, 1);
        add(1, 0, 32'h0,        1, 1, 1, 8'h08, 1, 1);
        add(1, 0, 32'h0,        1, 1, 1, 8'hAA, 0, 1);
        add(1, 0, 32'h0,        1, 1, 1, 8'hBB, 0, 1);
        add(1, 0, 32'h0,        1, 1, 1, 8'hCC, 0, 1);
        add(1, 0, 32'h0,        1, 1, 1, 8'hDD, 1, 1);
        add(0, 0, 32'h0,        1, 1, 0, 8'h00, 0, 1);
        // ---- reset mid-group ------------------------------------------
        add(1, 1, 32'h01020304, 1, 1, 0, 8'h00, 0, 0);
        add(1, 0, 32'h0,        1, 1, 1, 8'h01, 0, 0);
        add(1, 0, 32'h0,        1, 1, 1, 8'h02, 0, 0);
        add(0, 0, 32'h0,        1, 1, 1, 8'h03, 0, 0);
        add(1, 1, 32'h0000FFFF, 1, 1, 0, 8'h00, 0, 0);
        add(1, 0, 32'h0,        1, 1, 1, 8'h00, 0, 0);
        add(1, 0, 32'h0,        1, 1, 1, 8'h00, 0, 0);
        add(1, 0, 32'h0,        1, 1, 1, 8'hFF, 0, 0);
        add(1, 0, 32'h0,        1, 1, 1, 8'hFF, 1, 0);
        add(1, 0, 32'h0,        1, 1, 0, 8'h00, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].grp, vecs[i].rdy);
            if (vecs[i].chk) begin
                $display("vec %0d: val=%0b msg=%02h last=%0b ovf=%0b oerr=%0b",
                         i, out_val, out_msg, out_last, overflow, order_err);
                check($sformatf("v%0d out_val", i),   32'(out_val),   32'(vecs[i].ev));
                check($sformatf("v%0d out_msg", i),   32'(out_msg),   32'(vecs[i].em));
                check($sformatf("v%0d out_last", i),  32'(out_last),  32'(vecs[i].el));
                check($sformatf("v%0d overflow", i),  32'(overflow),  32'(vecs[i].eo));
                check($sformatf("v%0d order_err", i), 32'(order_err), 32'(0));
            end
        end

        // ---- order check: dropped unsorted group never flags ----------
        drive(0, 0, 32'h0, 0);
        drive(1, 1, 32'h01020304, 0);
        drive(1, 1, 32'h05060708, 0);
        drive(1, 1, 32'h09050302, 0);
        drive(1, 0, 32'h0, 0);
        $display("drop-unsorted: ovf=%0b oerr=%0b", overflow, order_err);
        check("drop overflow", 32'(overflow), 32'(1));
        check("drop order_err", 32'(order_err), 32'(0));

        // ---- order check: accepted unsorted group ---------------------
        drive(0, 0, 32'h0, 1);
        drive(1, 1, 32'h05020709, 1);
        check("oc pre order_err", 32'(order_err), 32'(0));
        check("oc pre out_val", 32'(out_val), 32'(0));
        drive(1, 0, 32'h0, 1);
        $display("unsorted e0: msg=%02h oerr=%0b", out_msg, order_err);
        check("oc order_err", 32'(order_err), 32'(EXP_OC));
        check("oc e0", 32'(out_msg), 32'h05);
        drive(1, 0, 32'h0, 1);
        check("oc e1", 32'(out_msg), 32'h02);
        drive(1, 0, 32'h0, 1);
        check("oc e2", 32'(out_msg), 32'h07);
        drive(1, 0, 32'h0, 1);
        check("oc e3", 32'(out_msg), 32'h09);
        check("oc e3 last", 32'(out_last), 32'(1));
        drive(1, 0, 32'h0, 1);
        $display("unsorted done: val=%0b oerr=%0b", out_val, order_err);
        check("oc done out_val", 32'(out_val), 32'(0));
        check("oc sticky order_err", 32'(order_err), 32'(EXP_OC));
        check("oc overflow", 32'(overflow), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
